stream_min_max: RTL and testbench

STREAM_MIN_MAX -- requirements
Module: stream_min_max

---
 rtl/minmax_pkg.sv | 13 +
 rtl/comparator_lt.sv | 17 +
 rtl/stream_min_max.sv | 115 +++++++++++
 tb/tb_stream_min_max.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// rtl/minmax_pkg.sv - shared state encoding and default widths for stream_min_max
package minmax_pkg;

  localparam int MINMAX_N_DEFAULT     = 32;
  localparam int MINMAX_CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } minmax_state_t;

endpackage

// File: rtl/comparator_lt.sv
// rtl/comparator_lt.sv - signed a < b from the sign of a one-bit-wider difference
module comparator_lt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  logic [N:0] diff;

  // Sign-extending both operands by one bit makes the subtraction overflow-free,
  // so the top bit of the difference is exactly the signed less-than result.
  assign diff = {a[N-1], a} - {b[N-1], b};
  assign lt   = diff[N];

endmodule

// File: rtl/stream_min_max.sv
// rtl/stream_min_max.sv - signed min/max/count of a beat stream; MINMAX_INDEX_EN adds min/max beat indices
module stream_min_max
  import minmax_pkg::*;
#(
  parameter int N     = MINMAX_N_DEFAULT,
  parameter int CNT_W = MINMAX_CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [N-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_min,
  output logic signed [N-1:0] out_max,
  output logic [CNT_W-1:0]    out_count
`ifdef MINMAX_INDEX_EN
  ,
  output logic [CNT_W-1:0]    out_min_idx,
  output logic [CNT_W-1:0]    out_max_idx
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  minmax_state_t       state;
  logic signed [N-1:0] min_r;
  logic signed [N-1:0] max_r;
  logic [CNT_W-1:0]    count_r;
  logic                new_min;
  logic                new_max;
`ifdef MINMAX_INDEX_EN
  logic [CNT_W-1:0]    min_idx_r;
  logic [CNT_W-1:0]    max_idx_r;
`endif

  // Handshake flags depend on state alone so no input reaches an output combinationally.
  assign in_ready  = (state != S_DONE);
  assign out_valid = (state == S_DONE);
  assign out_min   = min_r;
  assign out_max   = max_r;
  assign out_count = count_r;
`ifdef MINMAX_INDEX_EN
  assign out_min_idx = min_idx_r;
  assign out_max_idx = max_idx_r;
`endif

  // Strict less-than in both directions so ties keep the earliest beat.
  comparator_lt #(.N(N)) u_lt_min (
    .a  (in_data),
    .b  (min_r),
    .lt (new_min)
  );

  comparator_lt #(.N(N)) u_lt_max (
    .a  (max_r),
    .b  (in_data),
    .lt (new_max)
  );

  // Stream state machine and accumulation; count (and with it the next index) saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      min_r   <= '0;
      max_r   <= '0;
      count_r <= '0;
`ifdef MINMAX_INDEX_EN
      min_idx_r <= '0;
      max_idx_r <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            min_r   <= in_data;
            max_r   <= in_data;
            count_r <= CNT_W'(1);
`ifdef MINMAX_INDEX_EN
            min_idx_r <= '0;
            max_idx_r <= '0;
`endif
            state <= in_last ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            // count_r equals this beat's zero-based index, already saturated.
            if (new_min) begin
              min_r <= in_data;
`ifdef MINMAX_INDEX_EN
              min_idx_r <= count_r;
`endif
            end
            if (new_max) begin
              max_r <= in_data;
`ifdef MINMAX_INDEX_EN
              max_idx_r <= count_r;
`endif
            end
            if (count_r != CNT_MAX) count_r <= count_r + CNT_W'(1);
            if (in_last) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_min_max.sv
// tb/tb_stream_min_max.sv - randomized and directed bench for stream_min_max (honours MINMAX_INDEX_EN)
module tb_stream_min_max;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic signed [7:0] in_data;
  logic              in_valid, in_last, in_ready, out_valid, out_ready;
  logic signed [7:0] out_min, out_max;
  logic [15:0]       out_count;

  logic              s_in_valid, s_in_last, s_in_ready, s_out_valid, s_out_ready;
  logic signed [7:0] s_in_data, s_out_min, s_out_max;
  logic [1:0]        s_out_count;

`ifdef MINMAX_INDEX_EN
  logic [15:0] out_min_idx, out_max_idx;
  logic [1:0]  s_out_min_idx, s_out_max_idx;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  stream_min_max #(.N(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_count (out_count)
`ifdef MINMAX_INDEX_EN
    ,
    .out_min_idx (out_min_idx),
    .out_max_idx (out_max_idx)
`endif
  );

  stream_min_max #(.N(8), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_data   (s_in_data),
    .in_valid  (s_in_valid),
    .in_last   (s_in_last),
    .in_ready  (s_in_ready),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_min   (s_out_min),
    .out_max   (s_out_max),
    .out_count (s_out_count)
`ifdef MINMAX_INDEX_EN
    ,
    .out_min_idx (s_out_min_idx),
    .out_max_idx (s_out_max_idx)
`endif
  );

  // Reference: whole-stream min/max with first occurrence, count and indices capped at 2^cw-1.
  function automatic void model(input int v[$], input int cw,
                                output int mn, output int mx, output int cnt,
                                output int mni, output int mxi);
    int cap;
    cap = (1 << cw) - 1;
    mn = v[0]; mx = v[0]; mni = 0; mxi = 0;
    for (int i = 1; i < v.size(); i++) begin
      if (v[i] < mn) begin mn = v[i]; mni = (i > cap) ? cap : i; end
      if (v[i] > mx) begin mx = v[i]; mxi = (i > cap) ? cap : i; end
    end
    cnt = (v.size() > cap) ? cap : v.size();
  endfunction

  task automatic test_stream_case(input string name, input int v[$], input bit gaps);
    int mn, mx, cnt, mni, mxi;
    model(v, 16, mn, mx, cnt, mni, mxi);
    for (int i = 0; i < v.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_data  = 8'(v[i]);
      in_last  = (i == v.size() - 1);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i != v.size() - 1) begin
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL %s early_valid beat %0d: got %b want 0", name, i, out_valid);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL %s handshake: out_valid=%b in_ready=%b want 1/0", name, out_valid, in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_min !== 8'(mn) || out_max !== 8'(mx) || out_count !== 16'(cnt))
      $display("FAIL %s result: min=%0d max=%0d cnt=%0d want %0d %0d %0d",
               name, out_min, out_max, out_count, mn, mx, cnt);
    else pass_cnt++;
`ifdef MINMAX_INDEX_EN
    total_cnt++;
    if (out_min_idx !== 16'(mni) || out_max_idx !== 16'(mxi))
      $display("FAIL %s idx: min_idx=%0d max_idx=%0d want %0d %0d", name, out_min_idx, out_max_idx, mni, mxi);
    else pass_cnt++;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s consume: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_min !== 8'sd0 || out_max !== 8'sd0 || out_count !== 16'd0)
      $display("FAIL reset: in_ready=%b out_valid=%b min=%0d max=%0d cnt=%0d want 1 0 0 0 0",
               in_ready, out_valid, out_min, out_max, out_count);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    test_stream_case("mixed", '{5, -3, 7, 0}, 1'b0);
    test_stream_case("single_0x80", '{-128}, 1'b0);
    test_stream_case("ties", '{4, 4, 4}, 1'b0);
    test_stream_case("extremes", '{127, -128, 127, -128}, 1'b0);
  endtask

  task automatic test_hold();
    test_stream_case("pre_hold", '{1}, 1'b0);
    in_data = 8'sd10; in_last = 1'b0; in_valid = 1'b1; @(posedge clk); #1;
    in_data = -8'sd20;                                  @(posedge clk); #1;
    in_data = 8'sd30; in_last = 1'b1;                   @(posedge clk); #1;
    in_data = -8'sd5;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_min !== -8'sd20 || out_max !== 8'sd30 || out_count !== 16'd3)
        $display("FAIL hold cycle %0d: v=%b r=%b min=%0d max=%0d cnt=%0d want 1 0 -20 30 3",
                 c, out_valid, in_ready, out_min, out_max, out_count);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL hold_consume: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_min !== -8'sd5 || out_max !== -8'sd5 || out_count !== 16'd1)
      $display("FAIL hold_next: v=%b min=%0d max=%0d cnt=%0d want 1 -5 -5 1", out_valid, out_min, out_max, out_count);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_data = 8'sd3; in_last = 1'b0; in_valid = 1'b1; @(posedge clk); #1;
    in_data = -8'sd7;                                  @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 16'd0)
      $display("FAIL reset_mid: v=%b r=%b cnt=%0d want 0 1 0", out_valid, in_ready, out_count);
    else pass_cnt++;
    test_stream_case("after_abort", '{1, 2}, 1'b0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 25; s++) begin
      int v[$];
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) v.push_back(int'($urandom_range(0, 255)) - 128);
      test_stream_case($sformatf("rand%0d", s), v, 1'b1);
    end
  endtask

  task automatic test_saturate();
    int streams[2][$];
    int mn, mx, cnt, mni, mxi;
    streams[0] = '{9, 8, 7, 6, 5};
    for (int i = 0; i < 7; i++) streams[1].push_back(int'($urandom_range(0, 255)) - 128);
    for (int s = 0; s < 2; s++) begin
      model(streams[s], 2, mn, mx, cnt, mni, mxi);
      for (int i = 0; i < streams[s].size(); i++) begin
        s_in_data = 8'(streams[s][i]);
        s_in_last = (i == streams[s].size() - 1);
        s_in_valid = 1'b1;
        @(posedge clk); #1;
      end
      s_in_valid = 1'b0; s_in_last = 1'b0;
      total_cnt++;
      if (s_out_valid !== 1'b1 || s_out_min !== 8'(mn) || s_out_max !== 8'(mx) || s_out_count !== 2'(cnt))
        $display("FAIL sat%0d: v=%b min=%0d max=%0d cnt=%0d want 1 %0d %0d %0d",
                 s, s_out_valid, s_out_min, s_out_max, s_out_count, mn, mx, cnt);
      else pass_cnt++;
`ifdef MINMAX_INDEX_EN
      total_cnt++;
      if (s_out_min_idx !== 2'(mni) || s_out_max_idx !== 2'(mxi))
        $display("FAIL sat%0d idx: %0d %0d want %0d %0d", s, s_out_min_idx, s_out_max_idx, mni, mxi);
      else pass_cnt++;
`endif
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    s_in_data = '0; s_in_valid = 1'b0; s_in_last = 1'b0; s_out_ready = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
